// File: rtl/bp_pkg.sv
// Shared definitions for the PC-indexed branch history table predictor:
// RV32 opcodes recognised at fetch and the saturating-counter step used when
// EX trains an entry.
package bp_pkg;

  // Major opcodes, instr[6:0].
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Widest counter the table supports; narrower counters are zero-extended
  // into this width before stepping.
  localparam int unsigned CTR_BITS_MAX = 4;

  // One saturating step of a ctr_bits-wide counter held in the low bits of
  // ctr. Taken counts up and sticks at 2^ctr_bits-1; not-taken counts down
  // and sticks at 0.
  function automatic logic [CTR_BITS_MAX-1:0] bp_sat_next(
    input logic [CTR_BITS_MAX-1:0] ctr,
    input logic                    taken,
    input int unsigned             ctr_bits
  );
    logic [CTR_BITS_MAX:0]   full_scale;
    logic [CTR_BITS_MAX-1:0] max_val;
    logic [CTR_BITS_MAX-1:0] next_val;
    full_scale = (CTR_BITS_MAX+1)'(1) << ctr_bits;
    max_val    = CTR_BITS_MAX'(full_scale - (CTR_BITS_MAX+1)'(1));
    if (taken) begin
      next_val = (ctr >= max_val) ? max_val : ctr + CTR_BITS_MAX'(1);
    end else begin
      next_val = (ctr == '0) ? '0 : ctr - CTR_BITS_MAX'(1);
    end
    return next_val;
  endfunction

endpackage

// File: rtl/bp_target_gen.sv
// Fetch-stage decode for the branch predictor: classifies the fetched word as
// a conditional branch (B-type) or JAL, rebuilds its sign-extended immediate
// and forms the PC-relative target. Purely combinational.
module bp_target_gen
  import bp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instr,
  output logic            is_b,
  output logic            is_jal,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] target
);

  // Immediates as encoded, bit 0 always zero (halfword-aligned offsets).
  logic [12:0] imm_b_raw;
  logic [20:0] imm_j_raw;

  assign imm_b_raw = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j_raw = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Opcode classification and immediate selection; non-control-flow words
  // contribute a zero offset so target collapses to the fetch PC.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the if/else leaves it unassigned (which would infer a latch).
    is_b   = 1'b0;
    is_jal = 1'b0;
    imm    = '0;
    if (instr[6:0] == OPC_BRANCH) begin
      is_b = 1'b1;
      imm  = {{(XLEN-13){imm_b_raw[12]}}, imm_b_raw};
    end else if (instr[6:0] == OPC_JAL) begin
      is_jal = 1'b1;
      imm    = {{(XLEN-21){imm_j_raw[20]}}, imm_j_raw};
    end
  end

  // PC-relative target; the carry out is dropped so the sum wraps mod 2^XLEN.
  assign target = pc + imm;

endmodule

// File: rtl/branch_predictor_bht.sv
// Fetch-stage branch predictor built on a PC-indexed table of saturating
// counters. B-type branches follow the MSB of their entry, JAL is always
// taken, and an EX mispredict redirect (Eval_branch) overrides everything.
// Entries are trained from EX using the index captured at fetch.
//
// Build option: define BP_GSHARE_EN to XOR a non-speculative global history
// register into the fetch index (gshare). Without it there is no history
// state and the index is taken straight from the PC.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int ENTRIES  = 64,
  parameter  int CTR_BITS = 2,
  parameter  int GHR_BITS = 6,
  localparam int IDX_W    = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  PC,
  input  logic [XLEN-1:0]  instr,
  output logic [IDX_W-1:0] pred_index,
  output logic             predict_branch,
  output logic [XLEN-1:0]  Target_final,
  input  logic             Eval_branch,
  input  logic [XLEN-1:0]  Act_Target,
  input  logic             StateUpdateEnable,
  input  logic             PCSrcE,
  input  logic [IDX_W-1:0] upd_index
);

  // Reject configurations the indexing and counter logic cannot represent.
  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
    $error("branch_predictor_bht: ENTRIES must be a power of two >= 2");
  end
  if (CTR_BITS < 1 || CTR_BITS > CTR_BITS_MAX) begin : g_bad_ctr_bits
    $error("branch_predictor_bht: CTR_BITS must be in 1..4");
  end
  if (GHR_BITS < 1 || GHR_BITS > IDX_W) begin : g_bad_ghr_bits
    $error("branch_predictor_bht: GHR_BITS must be in 1..IDX_W");
  end
  if (XLEN < IDX_W + 2 || XLEN < 21) begin : g_bad_xlen
    $error("branch_predictor_bht: XLEN too narrow for index/immediates");
  end

  // ---------------------------------------------------------------------
  // Fetch decode and PC-relative target
  // ---------------------------------------------------------------------
  logic            is_b;
  logic            is_jal;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc_rel_target;

  bp_target_gen #(
    .XLEN (XLEN)
  ) u_target_gen (
    .pc     (PC),
    .instr  (instr),
    .is_b   (is_b),
    .is_jal (is_jal),
    .imm    (imm),
    .target (pc_rel_target)
  );

  // ---------------------------------------------------------------------
  // Fetch index
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0] pc_index;

  // Word-aligned PC bits select the entry; bits [1:0] never matter.
  assign pc_index = PC[IDX_W+1:2];

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr;
  logic [IDX_W-1:0]    ghr_ext;

  // Global history: shift in each resolved outcome from EX, oldest bit
  // falls off the top. Updated only on resolution, never speculatively.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state is written with non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!reset) begin
      ghr <= '0;
    end else if (StateUpdateEnable) begin
      ghr <= GHR_BITS'({ghr, PCSrcE});
    end
  end

  // History is zero-extended into the low index bits before hashing.
  always_comb begin
    ghr_ext                 = '0;
    ghr_ext[GHR_BITS-1:0]   = ghr;
  end

  assign pred_index = pc_index ^ ghr_ext;
`else
  assign pred_index = pc_index;
`endif

  // ---------------------------------------------------------------------
  // Counter table
  // ---------------------------------------------------------------------
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_next;
  logic [CTR_BITS-1:0] pred_ctr;

  // Saturating step for the entry EX is training this cycle.
  always_comb begin
    ctr_next = CTR_BITS'(bp_sat_next(CTR_BITS_MAX'(ctr_q[upd_index]),
                                     PCSrcE, CTR_BITS));
  end

  // Table storage: cleared to strong not-taken on reset, otherwise only the
  // entry named by upd_index moves, and only when EX resolves a branch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: this array is deliberately built from resettable flops, not
      // RAM, because the predictor must start from a known all-not-taken state.
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= '0;
      end
    end else if (StateUpdateEnable) begin
      ctr_q[upd_index] <= ctr_next;
    end
  end

  // Read port for fetch; sees the pre-update value when fetch and EX hit the
  // same entry in one cycle (no write-to-read bypass).
  assign pred_ctr = ctr_q[pred_index];

  // ---------------------------------------------------------------------
  // Prediction and final target
  // ---------------------------------------------------------------------
  assign predict_branch = Eval_branch
                        | (is_b & pred_ctr[CTR_BITS-1])
                        | is_jal;

  assign Target_final = Eval_branch ? Act_Target : pc_rel_target;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht (default parameters).
// Directed vector table, hand-written multi-cycle sequences and a randomized
// phase, all checked against a counter-table model kept here.
module tb_branch_predictor_bht;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 64;
  localparam int IDX_W   = 6;
  localparam int CTR_MAX = 3;   // 2-bit counters
  localparam int CTR_MID = 2;   // taken threshold

  logic             clk;
  logic             reset;
  logic [XLEN-1:0]  PC;
  logic [XLEN-1:0]  instr;
  logic [IDX_W-1:0] pred_index;
  logic             predict_branch;
  logic [XLEN-1:0]  Target_final;
  logic             Eval_branch;
  logic [XLEN-1:0]  Act_Target;
  logic             StateUpdateEnable;
  logic             PCSrcE;
  logic [IDX_W-1:0] upd_index;

  branch_predictor_bht dut (
    .clk               (clk),
    .reset             (reset),
    .PC                (PC),
    .instr             (instr),
    .pred_index        (pred_index),
    .predict_branch    (predict_branch),
    .Target_final      (Target_final),
    .Eval_branch       (Eval_branch),
    .Act_Target        (Act_Target),
    .StateUpdateEnable (StateUpdateEnable),
    .PCSrcE            (PCSrcE),
    .upd_index         (upd_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------
  // Reference model: an array of integer counters plus a history integer.
  // ---------------------------------------------------------------------
  int m_ctr [ENTRIES];
  int m_ghr;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 0;
    m_ghr = 0;
  endfunction

  function automatic void model_update(int idx, bit taken);
    if (taken) m_ctr[idx] = (m_ctr[idx] + 1 > CTR_MAX) ? CTR_MAX : m_ctr[idx] + 1;
    else       m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
    m_ghr = ((m_ghr * 2) + int'(taken)) % 64;
  endfunction

  function automatic int model_index(logic [31:0] pc);
    int idx;
    idx = int'((pc / 4) % ENTRIES);
`ifdef BP_GSHARE_EN
    idx = idx ^ m_ghr;
`endif
    return idx;
  endfunction

  // Instruction encoders: the bench chooses the immediate, so the expected
  // target is simply pc + chosen offset.
  function automatic logic [31:0] enc_b(int imm, logic [31:0] filler);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], filler[24:20], filler[19:15], filler[14:12],
            v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(int imm, logic [31:0] filler);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], filler[11:7], 7'b1101111};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One fetch/update cycle: drive after the falling edge, check combinational
  // outputs 1 time unit later, then advance the model at the rising edge.
  // kind: 0 = other opcode, 1 = B-type, 2 = JAL.
  task automatic step(input string name, input logic [31:0] pc, input logic [31:0] ins,
                      input int kind, input int imm, input bit eval, input logic [31:0] act,
                      input bit sue, input bit taken, input int upd);
    int          idx;
    bit          exp_pred;
    logic [31:0] exp_tgt;
    @(negedge clk);
    PC = pc; instr = ins; Eval_branch = eval; Act_Target = act;
    StateUpdateEnable = sue; PCSrcE = taken; upd_index = IDX_W'(upd);
    #1;
    idx      = model_index(pc);
    exp_pred = eval || (kind == 2) || (kind == 1 && m_ctr[idx] >= CTR_MID);
    exp_tgt  = eval ? act : pc + 32'(imm);
    check({name, ".idx"},  32'(pred_index),     32'(idx));
    check({name, ".pred"}, 32'(predict_branch), 32'(exp_pred));
    check({name, ".tgt"},  Target_final,        exp_tgt);
    @(posedge clk);
    if (sue) model_update(upd, taken);
  endtask

  // Directed vectors applied with an all-zero table.
  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] ins;
    bit          eval;
    logic [31:0] act;
    bit          exp_pred;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs [7];

  logic [31:0] beq16;
  logic [31:0] addi;
  logic [31:0] r;
  int          k, imm, upd;
  logic [31:0] pc;

  initial begin
    beq16 = enc_b(16, 32'h0);
    addi  = 32'h0010_0093;
    vecs[0] = '{"beq_p16",   32'h0000_0100, beq16,                 1'b0, 32'h0,         1'b0, 32'h0000_0110};
    vecs[1] = '{"jal_m8",    32'h0000_0200, enc_j(-8, 32'h0),      1'b0, 32'h0,         1'b1, 32'h0000_01F8};
    vecs[2] = '{"eval_over", 32'h0000_0040, addi,                  1'b1, 32'hDEAD_0000, 1'b1, 32'hDEAD_0000};
    vecs[3] = '{"other_op",  32'h0000_0300, addi,                  1'b0, 32'h0,         1'b0, 32'h0000_0300};
    vecs[4] = '{"jal_wrap",  32'hFFFF_FFFC, enc_j(8, 32'h80),      1'b0, 32'h0,         1'b1, 32'h0000_0004};
    vecs[5] = '{"b_minneg",  32'h0000_1000, enc_b(-4096, 32'h123), 1'b0, 32'h0,         1'b0, 32'h0000_0000};
    vecs[6] = '{"b_maxpos",  32'h0000_0040, enc_b(4094, 32'h4567), 1'b0, 32'h0,         1'b0, 32'h0000_103E};

    // Reset asserted: outputs are combinational, table reads as all zero.
    reset = 1'b0; PC = 32'h100; instr = beq16; Eval_branch = 1'b0; Act_Target = '0;
    StateUpdateEnable = 1'b0; PCSrcE = 1'b0; upd_index = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.pred", 32'(predict_branch), 32'd0);
    check("rst.tgt",  Target_final, 32'h0000_0110);
    @(negedge clk); reset = 1'b1;

    // Vector table.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      PC = vecs[i].pc; instr = vecs[i].ins; Eval_branch = vecs[i].eval;
      Act_Target = vecs[i].act; StateUpdateEnable = 1'b0;
      #1;
      check({vecs[i].name, ".pred"}, 32'(predict_branch), 32'(vecs[i].exp_pred));
      check({vecs[i].name, ".tgt"},  Target_final, vecs[i].exp_tgt);
    end

    // Two taken updates at index 5, then fetch PC=0x14.
    step("tr1", 32'h0, addi, 0, 0, 0, 0, 1, 1, 5);
    step("tr2", 32'h0, addi, 0, 0, 0, 0, 1, 1, 5);
    step("f14a", 32'h14, beq16, 1, 16, 0, 0, 0, 0, 0);

    // Saturate (four taken), then one not-taken fetched in the same cycle.
    for (int i = 0; i < 4; i++) step("sat", 32'h0, addi, 0, 0, 0, 0, 1, 1, 5);
    step("nt_same", 32'h14, beq16, 1, 16, 0, 0, 1, 0, 5);
    step("f14b", 32'h14, beq16, 1, 16, 0, 0, 0, 0, 0);

    // Same-cycle read/update at a weakly-not-taken entry: old value wins.
    step("w1", 32'h0, addi, 0, 0, 0, 0, 1, 1, 9);
    step("byp0", 32'h24, beq16, 1, 16, 0, 0, 1, 1, 9);
    step("byp1", 32'h24, beq16, 1, 16, 0, 0, 0, 0, 0);

    // Redirect and update together: update applies, target is Act_Target.
    step("ev_upd", 32'h30, beq16, 1, 16, 1, 32'hCAFE_0008, 1, 1, 12);
    step("ev_chk", 32'h30, beq16, 1, 16, 0, 0, 1, 1, 12);
    step("ev_chk2", 32'h30, beq16, 1, 16, 0, 0, 0, 0, 0);

    // Unknown instruction with redirect: outputs still defined; no state change.
    @(negedge clk);
    instr = 'x; Eval_branch = 1'b1; Act_Target = 32'hDEAD_0000; StateUpdateEnable = 1'b0;
    #1;
    check("x.pred", 32'(predict_branch), 32'd1);
    check("x.tgt",  Target_final, 32'hDEAD_0000);
    @(posedge clk);
    step("x_after5", 32'h14, beq16, 1, 16, 0, 0, 0, 0, 0);
    step("x_after12", 32'h30, beq16, 1, 16, 0, 0, 0, 0, 0);

    // Reset while an update is being presented: reset wins, table clears.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 3; j++) step("train", 32'h0, addi, 0, 0, 0, 0, 1, 1, i);
    @(negedge clk);
    StateUpdateEnable = 1'b1; PCSrcE = 1'b1; upd_index = 6'd3; reset = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b1; StateUpdateEnable = 1'b0;
    for (int i = 0; i < ENTRIES; i++) step("clr", 32'(i * 4), beq16, 1, 16, 0, 0, 0, 0, 0);
    step("clr_up", 32'h0, addi, 0, 0, 0, 0, 1, 1, 3);
    step("clr_chk", 32'hC, beq16, 1, 16, 0, 0, 0, 0, 0);

    // History-hashed index after three taken outcomes from a clean state.
    @(negedge clk); reset = 1'b0;
    @(posedge clk); model_reset();
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 3; i++) step("ghr", 32'h0, addi, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    PC = 32'h14; instr = beq16; Eval_branch = 1'b0; StateUpdateEnable = 1'b0;
    #1;
`ifdef BP_GSHARE_EN
    check("ghr.idx", 32'(pred_index), 32'd2);
`else
    check("ghr.idx", 32'(pred_index), 32'd5);
`endif

    // Randomized phase against the model.
    for (int n = 0; n < 400; n++) begin
      k   = $urandom_range(0, 2);
      r   = $urandom;
      pc  = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | ($urandom & 32'h3);
      upd = $urandom_range(0, 7);
      if (k == 1) begin
        imm = $urandom_range(0, 4095) * 2 - 4096;
        step("rnd_b", pc, enc_b(imm, r), 1, imm, ($urandom % 8) == 0, $urandom,
             $urandom % 2, $urandom % 2, upd);
      end else if (k == 2) begin
        imm = $urandom_range(0, (1 << 20) - 1) * 2 - (1 << 20);
        step("rnd_j", pc, enc_j(imm, r), 2, imm, ($urandom % 8) == 0, $urandom,
             $urandom % 2, $urandom % 2, upd);
      end else begin
        r[6:0] = (r[0]) ? 7'b0010011 : 7'b0110011;
        step("rnd_o", pc, r, 0, 0, ($urandom % 8) == 0, $urandom,
             $urandom % 2, $urandom % 2, upd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
